// File: rtl/err_compute_pkg.sv
// ---------------------------------------------------------------------------
// mr_err_pkg
// Shared types and constants for the line-sensor error computation path:
//   state_e    - sequencer states of err_compute
//   ERR_W      - width of the saturated signed error handed to the PID terms
//   ACC_W      - width of the signed weighted-sum accumulator
//   CH_WEIGHT  - signed weight applied to each of the eight sensor channels
// ---------------------------------------------------------------------------
package mr_err_pkg;

  localparam int ERR_W = 11;
  localparam int ACC_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONV,
    DONE
  } state_e;

  // Even channels pull the error positive, odd channels negative; the outer
  // sensor pairs carry progressively larger weights.
  localparam logic signed [ACC_W-1:0] CH_WEIGHT [8] = '{
    17'sd1, -17'sd1,
    17'sd2, -17'sd2,
    17'sd4, -17'sd4,
    17'sd8, -17'sd8
  };

endpackage

// File: rtl/err_compute_if.sv
// ---------------------------------------------------------------------------
// err_compute_if
// Bundles the control, A2D and error-output signals of err_compute.
//   strt      - request one full error computation
//   busy      - sequencer is not idle
//   chnnl     - A2D channel select
//   strt_cnv  - one-cycle A2D conversion start
//   cnv_cmplt - A2D done strobe
//   res       - unsigned A2D result, valid with cnv_cmplt
//   err_sat   - signed saturated error
//   err_vld   - one-cycle strobe marking a new err_sat
// master: the err_compute side. slave: the surrounding system (A2D, control,
// PID consumers).
// ---------------------------------------------------------------------------
interface err_compute_if;
  import mr_err_pkg::*;

  logic             strt;
  logic             busy;
  logic [2:0]       chnnl;
  logic             strt_cnv;
  logic             cnv_cmplt;
  logic [11:0]      res;
  logic [ERR_W-1:0] err_sat;
  logic             err_vld;

  modport master (
    input  strt, cnv_cmplt, res,
    output busy, chnnl, strt_cnv, err_sat, err_vld
  );

  modport slave (
    output strt, cnv_cmplt, res,
    input  busy, chnnl, strt_cnv, err_sat, err_vld
  );

endinterface

// File: rtl/err_compute_sat_s17_s11.sv
// ---------------------------------------------------------------------------
// sat_s17_s11
// Combinational saturation of a 17-bit signed value to the 11-bit signed
// error width.
//   din  - signed ACC_W-bit input
//   dout - signed ERR_W-bit result clamped to [-1024, +1023]
// ---------------------------------------------------------------------------
module sat_s17_s11
  import mr_err_pkg::*;
(
  input  logic signed [ACC_W-1:0] din,
  output logic        [ERR_W-1:0] dout
);

  localparam logic signed [ACC_W-1:0] POS_MAX = 17'sd1023;
  localparam logic signed [ACC_W-1:0] NEG_MIN = -17'sd1024;

  always_comb begin
    if (din > POS_MAX) begin
      dout = 11'h3FF;
    end else if (din < NEG_MIN) begin
      dout = 11'h400;
    end else begin
      dout = din[ERR_W-1:0];
    end
  end

endmodule

// File: rtl/err_compute.sv
// ---------------------------------------------------------------------------
// err_compute
// Walks the eight IR line-sensor channels through the shared A2D, weights
// each result by channel position, accumulates a signed error and publishes
// its 11-bit saturated value with a one-cycle err_vld strobe.
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - err_compute_if.master (strt/busy, A2D handshake, err_sat/err_vld)
// Parameter SETTLE_CYCLES (1..255): mux settle cycles before each conversion.
// ---------------------------------------------------------------------------
module err_compute
  import mr_err_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  err_compute_if.master    bus
);

  state_e                  state_q, state_d;
  logic [2:0]              chnnl_q, chnnl_d;
  logic [7:0]              settle_cnt_q, settle_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    strt_cnv_q, strt_cnv_d;
  logic [ERR_W-1:0]        err_sat_q, err_sat_d;
  logic                    err_vld_q, err_vld_d;

  logic signed [ACC_W-1:0] weighted;
  logic [ERR_W-1:0]        acc_sat;

  // res is zero-extended before the signed multiply so 4095 stays positive.
  assign weighted = $signed({5'b0, bus.res}) * CH_WEIGHT[chnnl_q];

  sat_s17_s11 u_sat (
    .din  (acc_q),
    .dout (acc_sat)
  );

  always_comb begin
    state_d      = state_q;
    chnnl_d      = chnnl_q;
    settle_cnt_d = settle_cnt_q;
    acc_d        = acc_q;
    strt_cnv_d   = 1'b0;
    err_sat_d    = err_sat_q;
    err_vld_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.strt) begin
          acc_d        = '0;
          chnnl_d      = 3'd0;
          settle_cnt_d = 8'd0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = 8'd0;
          strt_cnv_d   = 1'b1;
          state_d      = CONV;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      CONV: begin
        // strt_cnv_q is high only in the first CONV cycle; a done strobe
        // there cannot belong to the conversion just launched.
        if (!strt_cnv_q && bus.cnv_cmplt) begin
          acc_d = acc_q + weighted;
          if (chnnl_q == 3'd7) begin
            state_d = DONE;
          end else begin
            chnnl_d      = chnnl_q + 3'd1;
            settle_cnt_d = 8'd0;
            state_d      = SETTLE;
          end
        end
      end
      DONE: begin
        err_sat_d = acc_sat;
        err_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chnnl_q      <= 3'd0;
      settle_cnt_q <= 8'd0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      strt_cnv_q   <= 1'b0;
      err_sat_q    <= '0;
      err_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      chnnl_q      <= chnnl_d;
      settle_cnt_q <= settle_cnt_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      strt_cnv_q   <= strt_cnv_d;
      err_sat_q    <= err_sat_d;
      err_vld_q    <= err_vld_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.chnnl    = chnnl_q;
  assign bus.strt_cnv = strt_cnv_q;
  assign bus.err_sat  = err_sat_q;
  assign bus.err_vld  = err_vld_q;

endmodule
